// File: rtl/uram_rd_streamer.sv
// uram_rd_streamer
//   Read-side sequencer for a fixed-latency URAM read port. A start command
//   issues one burst of reads over a contiguous address range. The returned
//   words are buffered and presented as a valid/ready stream. Reads are only
//   issued while buffer space is guaranteed, so a returning word always has a
//   free FIFO slot.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle burst request, honoured only when idle
//   base_addr, length    : first address and word count, captured with start
//   busy, done           : burst in progress / one-cycle completion pulse
//   ram_addr_vld, ram_addr : read request to the RAM
//   ram_dout_vld, ram_dout : delayed read data from the RAM
//   m_valid, m_data, m_last, m_ready : output stream
module uram_rd_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_addr_vld,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_dout_vld,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  // The FIFO must cover the full read pipeline for back-to-back issue.
  if ((RD_LATENCY < 32'd1) || (FIFO_DEPTH < RD_LATENCY + 32'd1) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0)) begin : g_param_check
    $error("uram_rd_streamer: illegal RD_LATENCY / FIFO_DEPTH combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issued_q, issued_d;
  logic [LEN_W-1:0]      rcv_q, rcv_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  addr_vld_q, addr_vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];

  logic                  push_s;
  logic                  pop_s;
  logic                  push_last_s;
  logic                  credit_ok_s;
  logic [CNT_W:0]        credit_sum_s;

  // Returns with nothing outstanding are stale pipeline contents (e.g. after a
  // reset mid-burst) and are dropped.
  assign push_s       = ram_dout_vld && (out_q != {CNT_W{1'b0}});
  assign pop_s        = m_valid && m_ready;
  assign push_last_s  = (rcv_q == (len_q - LEN_ONE));
  // Reads in flight plus words buffered must never exceed the FIFO size.
  assign credit_sum_s = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit_ok_s  = (credit_sum_s < DEPTH_C);

  assign busy         = busy_q;
  assign done         = done_q;
  assign ram_addr_vld = addr_vld_q;
  assign ram_addr     = addr_q;
  assign m_valid      = (cnt_q != {CNT_W{1'b0}});
  assign m_data       = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_last       = m_valid && mem_q[rd_ptr_q][DATA_WIDTH];

  // Burst sequencing: start capture, read issue and completion.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    addr_vld_d = 1'b0;
    addr_d     = addr_q;
    rcv_d      = push_s ? (rcv_q + LEN_ONE) : rcv_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          rcv_d  = {LEN_W{1'b0}};
          if (length != {LEN_W{1'b0}}) begin
            // First read goes out straight from IDLE to save a cycle of latency.
            addr_vld_d = 1'b1;
            addr_d     = base_addr;
            issued_d   = LEN_ONE;
            state_d    = (length == LEN_ONE) ? ST_DRAIN : ST_RUN;
          end else begin
            issued_d = {LEN_W{1'b0}};
            state_d  = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (credit_ok_s && (issued_q < len_q)) begin
          addr_vld_d = 1'b1;
          addr_d     = base_q + issued_q[ADDR_WIDTH-1:0];
          issued_d   = issued_q + LEN_ONE;
          state_d    = ((issued_q + LEN_ONE) == len_q) ? ST_DRAIN : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && m_last) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_FIN);
  end

  // Outstanding-read credit counter and FIFO pointer/occupancy bookkeeping.
  always_comb begin
    case ({addr_vld_d, push_s})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= {ADDR_WIDTH{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      issued_q   <= {LEN_W{1'b0}};
      rcv_q      <= {LEN_W{1'b0}};
      out_q      <= {CNT_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_vld_q <= 1'b0;
      addr_q     <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rcv_q      <= rcv_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_vld_q <= addr_vld_d;
      addr_q     <= addr_d;
    end
  end

  // FIFO storage: data word plus its end-of-burst tag; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {push_last_s, ram_dout};
    end
  end

endmodule

// File: tb/tb_uram_rd_streamer.sv
module tb_uram_rd_streamer;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int RD_LAT = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_addr_vld, ram_dout_vld, m_valid, m_last, m_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout, m_data;

  always #5 clk = ~clk;

  uram_rd_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr_vld(ram_addr_vld), .ram_addr(ram_addr),
    .ram_dout_vld(ram_dout_vld), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready));

  // RAM contents: a fixed, address-unique pattern.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, 2'b00, a, 8'hC3};
  endfunction

  // Fixed-latency RAM model; its pipeline is not reset, like a real URAM.
  logic [RD_LAT-1:0] vld_pipe = '0;
  logic [AW-1:0]     a_pipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) a_pipe[i] = '0;
  always @(posedge clk) begin
    vld_pipe <= {vld_pipe[RD_LAT-2:0], ram_addr_vld};
    a_pipe[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign ram_dout_vld = vld_pipe[RD_LAT-1];
  assign ram_dout     = ram_word(a_pipe[RD_LAT-1]);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required nothing", name, act);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         exp_beats[$];
  logic [AW-1:0] exp_addrs[$];
  logic [AW-1:0] obs_addrs[$];
  int            obs_acyc[$];
  logic [DW-1:0] obs_data[$];
  int  reads_n = 0, beats_n = 0, done_n = 0, busy_n = 0, valid_n = 0;
  int  inflight = 0, max_inflight = 0;
  int  acc_cyc = 0, first_valid_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
  bit  idle_m = 1'b1, done_pend = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Behavioural model and compare process, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      idle_m = 1'b1; done_pend = 1'b0; stall_prev = 1'b0; inflight = 0;
      exp_addrs.delete(); exp_beats.delete();
    end else begin
      if (ram_addr_vld) begin
        reads_n++; inflight++;
        obs_addrs.push_back(ram_addr); obs_acyc.push_back(cyc);
        if (inflight > max_inflight) max_inflight = inflight;
        chk("credit_limit", (inflight <= DEPTH), 1);
        if (exp_addrs.size() == 0) fail_now("extra_read", ram_addr);
        else chk("ram_addr", ram_addr, exp_addrs.pop_front());
      end
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (m_valid) begin
        valid_n++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_beats.size() == 0) fail_now("extra_beat", m_data);
        else begin
          chk("m_data", m_data, exp_beats[0].d);
          chk("m_last", m_last, exp_beats[0].l);
          if (m_ready) begin
            void'(exp_beats.pop_front());
            beats_n++; inflight--;
            obs_data.push_back(m_data);
            if (m_last) last_beat_cyc = cyc;
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      if (busy) busy_n++;
      if (done) begin
        done_n++; done_cyc = cyc;
        chk("busy_low_at_done", busy, 0);
        if (!done_pend) fail_now("spurious_done", done_n);
        done_pend = 1'b0;
      end
      // Start is sampled at the next rising edge; only honoured when idle.
      if (start && idle_m) begin
        idle_m = 1'b0; done_pend = 1'b1;
        acc_cyc = cyc; first_valid_cyc = -1;
        for (int i = 0; i < int'(length); i++) begin
          logic [AW-1:0] a;
          a = base_addr + AW'(i);
          exp_addrs.push_back(a);
          exp_beats.push_back('{d: ram_word(a), l: (i == int'(length) - 1)});
        end
      end
      if (done) idle_m = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_n < target; i++) tick();
    chk(name, done_n, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr_vld"}, ram_addr_vld, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, d0, r0, v0, bs0;
    logic [AW-1:0] wrap_exp [4];
    wrap_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: basic burst of four.
    m_ready = 1'b1;
    d0 = done_n; a0 = obs_addrs.size(); b0 = obs_data.size();
    pulse_start(14'h0010, 15'd4);
    chk("t1_busy_after_start", busy, 1);
    wait_done(d0 + 1, 60, "t1_done");
    tick();
    chk("t1_reads", obs_addrs.size() - a0, 4);
    if (obs_addrs.size() - a0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", obs_addrs[a0+i], 14'h0010 + i);
        chk("t1_addr_cycle", obs_acyc[a0+i] - obs_acyc[a0], i);
      end
    end
    chk("t1_beats", obs_data.size() - b0, 4);
    if (obs_data.size() - b0 == 4) chk("t1_data0", obs_data[b0], 32'h4A0010C3);
    chk("t1_latency_ok", (first_valid_cyc - acc_cyc <= RD_LAT + 2), 1);
    chk("t1_done_after_last", done_cyc - last_beat_cyc, 1);
    chk("t1_done_count", done_n - d0, 1);

    // Test 2: address wrap.
    d0 = done_n; a0 = obs_addrs.size(); b0 = obs_data.size();
    pulse_start(14'h3FFE, 15'd4);
    wait_done(d0 + 1, 60, "t2_done");
    chk("t2_reads", obs_addrs.size() - a0, 4);
    if (obs_addrs.size() - a0 == 4)
      for (int i = 0; i < 4; i++) chk("t2_wrap_addr", obs_addrs[a0+i], wrap_exp[i]);
    if (obs_data.size() - b0 == 4) chk("t2_data1", obs_data[b0+1], 32'hA53FFFC3);

    // Test 3: zero-length burst.
    tick();
    d0 = done_n; r0 = reads_n; v0 = valid_n; bs0 = busy_n;
    pulse_start(14'h0100, 15'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("t3_done_count", done_n - d0, 1);
    chk("t3_done_delay_ok", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
    chk("t3_no_reads", reads_n - r0, 0);
    chk("t3_no_valid", valid_n - v0, 0);
    chk("t3_busy_never", busy_n - bs0, 0);

    // Test 4: backpressure, 32 words.
    m_ready = 1'b0;
    d0 = done_n; r0 = reads_n; b0 = beats_n;
    pulse_start(14'h0200, 15'd32);
    for (int i = 0; i < 19; i++) tick();
    chk("t4_reads_while_stalled", reads_n - r0, DEPTH);
    chk("t4_no_beats_while_stalled", beats_n - b0, 0);
    chk("t4_valid_held", m_valid, 1);
    for (int i = 0; i < 400 && done_n < d0 + 1; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    chk("t4_done", done_n - d0, 1);
    chk("t4_beats", beats_n - b0, 32);
    chk("t4_max_inflight", max_inflight, DEPTH);
    m_ready = 1'b1;
    tick();

    // Test 5: reset with three reads in flight.
    d0 = done_n; r0 = reads_n;
    pulse_start(14'h0300, 15'd16);
    tick(); tick(); tick();
    chk("t5_reads_before_reset", reads_n - r0, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_reset");
    tick();
    rst_n = 1'b1;
    r0 = reads_n; v0 = valid_n;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_stale_no_valid", valid_n - v0, 0);
    chk("t5_no_reads", reads_n - r0, 0);
    chk("t5_no_done", done_n - d0, 0);
    b0 = beats_n; d0 = done_n;
    pulse_start(14'h0020, 15'd2);
    wait_done(d0 + 1, 60, "t5_after_done");
    chk("t5_after_beats", beats_n - b0, 2);

    // Test 6: starts during RUN and during FIN are ignored.
    tick();
    d0 = done_n; r0 = reads_n; b0 = beats_n;
    pulse_start(14'h0040, 15'd6);
    tick();
    pulse_start(14'h1000, 15'd3);
    for (int i = 0; i < 100 && !done; i++) tick();
    chk("t6_fin_seen", done, 1);
    pulse_start(14'h2000, 15'd5);
    for (int i = 0; i < 12; i++) tick();
    chk("t6_done_count", done_n - d0, 1);
    chk("t6_reads", reads_n - r0, 6);
    chk("t6_beats", beats_n - b0, 6);
    chk("t6_model_drained", exp_beats.size() + exp_addrs.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uram_rd_streamer.md
Name: uram_rd_streamer

Overview:
- Read-side sequencer for a fixed-latency dual-port URAM.
- Drives the read-address/valid interface, then collects the delayed read data and valid.
- Presents the data as a valid/ready stream with backpressure.
- Issues one burst per start command over a contiguous address range. Uses credit-based flow control so no read data is ever dropped.

Parameters:
- DATA_WIDTH, 32, width of RAM read data and stream data.
- ADDR_WIDTH, 14, RAM address width.
- RD_LATENCY, 3, cycles from ram_addr_vld to ram_dout_vld. Must be ≥ 1.
- FIFO_DEPTH, 8, output buffer entries. Power of two, must be ≥ RD_LATENCY+1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst. Sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first read address, captured with start.
- length  input  ADDR_WIDTH+1  number of words, captured with start. 0 is legal.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the burst completes.
- ram_addr_vld  output  1  read request to RAM.
- ram_addr  output  ADDR_WIDTH  read address to RAM.
- ram_dout_vld  input  1  read data valid from RAM.
- ram_dout  input  DATA_WIDTH  read data from RAM.
- m_valid  output  1  stream data valid.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  marks the final word of the burst.
- m_ready  input  1  stream sink ready.

Behaviour:
- Reset (async assert, sync release) sets outputs and state as follows:
  - busy=0, done=0, ram_addr_vld=0, ram_addr=0, m_valid=0, m_last=0.
  - FSM=IDLE; FIFO empty; outstanding counter=0; issue and receive counters=0.
  - m_data is don't-care.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 captures base_addr and length.
  - length≠0 → RUN. length=0 → FIN, so no RAM read and no stream beat occur.
  - start while not IDLE is ignored.
- RUN:
  - ram_addr_vld is registered. It asserts in a cycle only when outstanding + fifo_count < FIFO_DEPTH and issued < length.
  - ram_addr = base_addr + issued, taken modulo 2^ADDR_WIDTH (wraps 0x3FFF→0x0000 at default width).
  - When issued reaches length → DRAIN.
- DRAIN: stays until the beat with m_last is accepted (m_valid & m_ready & m_last) → FIN.
- FIN: done=1 for exactly one cycle, busy=0 → IDLE. A start in the FIN cycle is ignored.
- busy=1 in RUN and DRAIN only.
- Outstanding counter:
  - +1 per issued read, −1 per ram_dout_vld accepted.
  - Simultaneous issue and return leaves it unchanged.
  - ram_dout_vld while outstanding=0 is discarded; this covers stale RAM pipeline contents after a mid-burst reset.
- FIFO:
  - ram_dout is pushed on ram_dout_vld. Credit accounting guarantees no push when full; the bench asserts this.
  - Simultaneous push and pop is legal at any occupancy, including full and empty.
  - m_valid = FIFO not empty. m_data = head entry, with registered or first-word-fall-through timing.
  - m_valid and m_data must hold stable while m_valid & !m_ready.
- m_last:
  - A receive counter counts pushed words; the entry whose index is length−1 is tagged last.
  - m_last is valid only with m_valid.
- Throughput: with m_ready held high, one word per cycle sustained after an initial latency.
- Latency: first m_valid ≤ RD_LATENCY+2 cycles after the cycle start is accepted.
- Reset mid-burst: everything returns to reset values immediately. No done pulse, and no further RAM reads.

Test Plan:
- start, base_addr=0x0010, length=4, m_ready=1:
  - ram_addr 0x10,0x11,0x12,0x13 on consecutive cycles.
  - m_data matches the RAM contents in order; m_last on the 4th beat only.
  - done pulses once, one cycle after the last beat; busy low the same cycle.
- base_addr=0x3FFE, length=4 → reads 0x3FFE,0x3FFF,0x0000,0x0001; stream order preserved.
- length=0 → no ram_addr_vld, no m_valid; done pulse 2 cycles after start; busy never high.
- length=32, m_ready low for the first 20 cycles then toggling 1/0:
  - ram_addr_vld stops after 8 outstanding-plus-buffered reads.
  - No FIFO overflow; all 32 words delivered in order with m_data stable while stalled.
- Assert rst_n low mid-burst with 3 reads in flight:
  - All outputs at reset values.
  - The late ram_dout_vld pulses are discarded.
  - A following burst of length=2 delivers exactly 2 correct words.
- start pulsed during RUN and during FIN → ignored; captured base_addr/length unchanged; exactly one done per accepted start.
